// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 expression collector.
package l2_pkg;

  typedef enum logic [2:0] {
    S_A1,
    S_A2,
    S_OP,
    S_B1,
    S_B2,
    S_EQ,
    S_START,
    S_WAIT
  } l2_state_e;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] EQ    = 8'h3D;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] SPACE = 8'h20;

  localparam int unsigned L2_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/l2_char_class.sv
// Combinational ASCII classifier for the expression collector.
module l2_char_class
  import l2_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic       is_op,
  output logic       is_term,
  output logic       is_space
);

  always_comb begin
    is_digit = (ch >= ZERO) && (ch <= NINE);
    is_op    = (ch == PLUS) || (ch == MINUS);
    is_term  = (ch == EQ) || (ch == CR);
    is_space = (ch == SPACE);
  end

endmodule

// File: rtl/l2_expr_collector.sv
// Parses "DD op DD term" from an rx byte stream, latches operands, starts the
// adder and holds operands until done or timeout.
module l2_expr_collector
  import l2_pkg::*;
#(
  parameter int unsigned TIMEOUT = L2_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       Gl_rst_n,
  input  logic [7:0] Gl_rx_data,
  input  logic       Gl_rx_valid,
  input  logic       Gl_adder_done,
  output logic [7:0] L2p_r11,
  output logic [7:0] L2p_r12,
  output logic [7:0] L2p_r21,
  output logic [7:0] L2p_r22,
  output logic       L2p_subtract,
  output logic       L2p_adder_start,
  output logic       L2p_busy,
  output logic       L2p_err,
  output logic       L2p_drop
);

  l2_state_e  state_q, state_d;
  logic [7:0] r11_q, r11_d, r12_q, r12_d, r21_q, r21_d, r22_q, r22_d;
  logic       sub_q, sub_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, start_d, busy_q, busy_d, err_q, err_d, drop_q, drop_d;

  logic is_digit, is_op, is_term, is_space;
  logic take;

  l2_char_class u_class (
    .ch       (Gl_rx_data),
    .is_digit (is_digit),
    .is_op    (is_op),
    .is_term  (is_term),
    .is_space (is_space)
  );

  // A non-space strobe that a collecting state must either accept or reject.
  assign take = Gl_rx_valid && !is_space;

  always_comb begin
    state_d = state_q;
    r11_d   = r11_q;
    r12_d   = r12_q;
    r21_d   = r21_q;
    r22_d   = r22_q;
    sub_d   = sub_q;
    cnt_d   = '0;
    err_d   = 1'b0;
    drop_d  = 1'b0;

    unique case (state_q)
      S_A1: if (take) begin
        if (is_digit) begin r11_d = Gl_rx_data; state_d = S_A2; end
        else          begin err_d = 1'b1;       state_d = S_A1; end
      end
      S_A2: if (take) begin
        if (is_digit) begin r12_d = Gl_rx_data; state_d = S_OP; end
        else          begin err_d = 1'b1;       state_d = S_A1; end
      end
      S_OP: if (take) begin
        if (is_op) begin sub_d = (Gl_rx_data == MINUS); state_d = S_B1; end
        else       begin err_d = 1'b1;                  state_d = S_A1; end
      end
      S_B1: if (take) begin
        if (is_digit) begin r21_d = Gl_rx_data; state_d = S_B2; end
        else          begin err_d = 1'b1;       state_d = S_A1; end
      end
      S_B2: if (take) begin
        if (is_digit) begin r22_d = Gl_rx_data; state_d = S_EQ; end
        else          begin err_d = 1'b1;       state_d = S_A1; end
      end
      S_EQ: if (take) begin
        if (is_term) state_d = S_START;
        else begin err_d = 1'b1; state_d = S_A1; end
      end
      S_START: begin
        drop_d  = Gl_rx_valid;
        cnt_d   = cnt_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        drop_d = Gl_rx_valid;
        // Counter equals cycles since the start cycle; done wins over timeout.
        if (Gl_adder_done) begin
          state_d = S_A1;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_A1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase

    start_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge Gl_rst_n) begin
    if (!Gl_rst_n) begin
      state_q <= S_A1;
      r11_q   <= ZERO;
      r12_q   <= ZERO;
      r21_q   <= ZERO;
      r22_q   <= ZERO;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r11_q   <= r11_d;
      r12_q   <= r12_d;
      r21_q   <= r21_d;
      r22_q   <= r22_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign L2p_r11         = r11_q;
  assign L2p_r12         = r12_q;
  assign L2p_r21         = r21_q;
  assign L2p_r22         = r22_q;
  assign L2p_subtract    = sub_q;
  assign L2p_adder_start = start_q;
  assign L2p_busy        = busy_q;
  assign L2p_err         = err_q;
  assign L2p_drop        = drop_q;

endmodule
